// File: rtl/grf_write_arbiter.sv
// Two-port write arbiter for the general register file. Round-robin grant,
// one-cycle registered write stage, in-flight busy mask and contention counter.
module grf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_ready,
  output logic                   WE,
  output logic [ADDR_W-1:0]      RegAddr,
  output logic [DATA_W-1:0]      WD,
  output logic [(1<<ADDR_W)-1:0] busy_mask,
  output logic [CNT_W-1:0]       conflict_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              elig0, elig1, zero0, zero1;
  logic              grant0, grant1;
  logic              rr_ptr_q, rr_ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Address 0 is hardwired in the register file: accept and drop it without
  // letting it compete for the write port.
  always_comb begin
    elig0  = req0_valid && (req0_addr != '0);
    elig1  = req1_valid && (req1_addr != '0);
    zero0  = req0_valid && (req0_addr == '0);
    zero1  = req1_valid && (req1_addr == '0);
    grant0 = elig0 && (!elig1 || !rr_ptr_q);
    grant1 = elig1 && (!elig0 ||  rr_ptr_q);
    req0_ready = !rst && (grant0 || zero0);
    req1_ready = !rst && (grant1 || zero1);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = grant0 || grant1;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    if (grant0) begin
      rr_ptr_d = 1'b1;
      addr_d   = req0_addr;
      data_d   = req0_data;
    end else if (grant1) begin
      rr_ptr_d = 1'b0;
      addr_d   = req1_addr;
      data_d   = req1_data;
    end
    if (elig0 && elig1) cnt_d = sat_inc(cnt_q);
  end

  // Output stage: single registered write toward the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    if (we_q) busy_mask[addr_q] = 1'b1;
  end

  assign WE           = we_q;
  assign RegAddr      = addr_q;
  assign WD           = data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter: reset, single grant, round-robin
// contention, zero-address discard, mid-flight reset and counter saturation.
module tb_grf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        WE;
  logic [4:0]  RegAddr;
  logic [31:0] WD;
  logic [31:0] busy_mask;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .WE(WE), .RegAddr(RegAddr), .WD(WD), .busy_mask(busy_mask), .conflict_cnt(conflict_cnt)
  );

  task automatic clear_reqs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h22;
    @(posedge clk); #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b exp 0", req1_ready); end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", WE); end
    checks++; if (RegAddr !== 5'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", RegAddr); end
    checks++; if (WD !== 32'd0) begin errors++; $display("FAIL rst_wd got %h exp 0", WD); end
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy_mask); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", conflict_cnt); end
    rst = 1'b0;
    clear_reqs();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1234;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b exp 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %b exp 0", req1_ready); end
    @(posedge clk); #1;
    clear_reqs();
    checks++; if (WE !== 1'b1) begin errors++; $display("FAIL single_we got %b exp 1", WE); end
    checks++; if (RegAddr !== 5'd5) begin errors++; $display("FAIL single_addr got %0d exp 5", RegAddr); end
    checks++; if (WD !== 32'h1234) begin errors++; $display("FAIL single_wd got %h exp 1234", WD); end
    checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL single_busy got %h exp 20", busy_mask); end
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready got %b exp 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL idle_we got %b exp 0", WE); end
    checks++; if (RegAddr !== 5'd5) begin errors++; $display("FAIL idle_addr_hold got %0d exp 5", RegAddr); end
    checks++; if (WD !== 32'h1234) begin errors++; $display("FAIL idle_wd_hold got %h exp 1234", WD); end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL idle_busy got %h exp 0", busy_mask); end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA0003;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBBBB0007;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_c0_ready got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b1 || RegAddr !== 5'd3 || WD !== 32'hAAAA0003) begin errors++; $display("FAIL cont_w0 got we=%b a=%0d d=%h exp we=1 a=3 d=aaaa0003", WE, RegAddr, WD); end
    checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL cont_cnt0 got %0d exp 1", conflict_cnt); end
    req0_valid = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL cont_c1_ready got %b exp 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b1 || RegAddr !== 5'd7 || WD !== 32'hBBBB0007) begin errors++; $display("FAIL cont_w1 got we=%b a=%0d d=%h exp we=1 a=7 d=bbbb0007", WE, RegAddr, WD); end
    checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL cont_cnt1 got %0d exp 1", conflict_cnt); end
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL cont_busy got %h exp 80", busy_mask); end
    clear_reqs();
  endtask

  // Entry state: rr_ptr=0, conflict_cnt=1
  task automatic test_sustained();
    req0_valid = 1'b1; req0_addr = 5'd11; req0_data = 32'h0A0A0A0A;
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'h0B0B0B0B;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL sust_ready%0d got %b%b exp %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); end
      @(posedge clk); #1;
      checks++; if (RegAddr !== ((i % 2 == 0) ? 5'd11 : 5'd12)) begin errors++; $display("FAIL sust_addr%0d got %0d exp %0d", i, RegAddr, (i % 2 == 0) ? 11 : 12); end
      checks++; if (conflict_cnt !== 16'(2 + i)) begin errors++; $display("FAIL sust_cnt%0d got %0d exp %0d", i, conflict_cnt, 2 + i); end
    end
    req0_valid = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL sust_solo_ready got %b exp 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (conflict_cnt !== 16'd5) begin errors++; $display("FAIL sust_solo_cnt got %0d exp 5", conflict_cnt); end
    checks++; if (WE !== 1'b1 || RegAddr !== 5'd12) begin errors++; $display("FAIL sust_solo_w got we=%b a=%0d exp we=1 a=12", WE, RegAddr); end
    clear_reqs();
  endtask

  // Entry state: rr_ptr=0, conflict_cnt=5
  task automatic test_same_addr();
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'd111;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'd222;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL same_c0_ready got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WD !== 32'd111 || RegAddr !== 5'd10) begin errors++; $display("FAIL same_w0 got a=%0d d=%0d exp a=10 d=111", RegAddr, WD); end
    checks++; if (conflict_cnt !== 16'd6) begin errors++; $display("FAIL same_cnt got %0d exp 6", conflict_cnt); end
    req0_valid = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL same_c1_ready got %b exp 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WD !== 32'd222 || RegAddr !== 5'd10 || WE !== 1'b1) begin errors++; $display("FAIL same_w1 got we=%b a=%0d d=%0d exp we=1 a=10 d=222", WE, RegAddr, WD); end
    checks++; if (busy_mask !== 32'h400) begin errors++; $display("FAIL same_busy got %h exp 400", busy_mask); end
    clear_reqs();
  endtask

  // Entry state: rr_ptr=0, conflict_cnt=6
  task automatic test_zero_addr();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'd5;
    @(posedge clk); #1;
    clear_reqs();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hDEAD;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'd99;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b11) begin errors++; $display("FAIL zero_ready got %b exp 11", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b1 || RegAddr !== 5'd9 || WD !== 32'd99) begin errors++; $display("FAIL zero_w got we=%b a=%0d d=%h exp we=1 a=9 d=63", WE, RegAddr, WD); end
    checks++; if (conflict_cnt !== 16'd6) begin errors++; $display("FAIL zero_cnt got %0d exp 6", conflict_cnt); end
    req0_addr = 5'd2; req0_data = 32'd2;
    req1_addr = 5'd3; req1_data = 32'd3;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL zero_rr_ready got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (conflict_cnt !== 16'd7 || RegAddr !== 5'd2) begin errors++; $display("FAIL zero_rr_w got cnt=%0d a=%0d exp cnt=7 a=2", conflict_cnt, RegAddr); end
    clear_reqs();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hBEEF;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL zero_solo_ready got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b0 || RegAddr !== 5'd2 || WD !== 32'd2) begin errors++; $display("FAIL zero_solo_w got we=%b a=%0d d=%h exp we=0 a=2 d=2", WE, RegAddr, WD); end
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'd44;
    @(posedge clk); #1;
    checks++; if (WE !== 1'b1 || busy_mask !== 32'h10) begin errors++; $display("FAIL mid_w got we=%b busy=%h exp we=1 busy=10", WE, busy_mask); end
    rst = 1'b1;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'd88;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL mid_ready got %b exp 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b0 || busy_mask !== 32'h0) begin errors++; $display("FAIL mid_drop got we=%b busy=%h exp we=0 busy=0", WE, busy_mask); end
    checks++; if (conflict_cnt !== 16'd0 || RegAddr !== 5'd0 || WD !== 32'd0) begin errors++; $display("FAIL mid_clr got cnt=%0d a=%0d d=%h exp 0 0 0", conflict_cnt, RegAddr, WD); end
    rst = 1'b0;
    clear_reqs();
  endtask

  task automatic test_saturation();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'd1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'd2;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp fffe", conflict_cnt); end
    @(posedge clk); #1;
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got %h exp ffff", conflict_cnt); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", conflict_cnt); end
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    test_reset();
    test_single();
    test_contention();
    test_sustained();
    test_same_addr();
    test_zero_addr();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_write_arbiter.md
GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

Interface
REQ-001 The block SHALL have the following ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 (pipeline writeback) write request.
- req0_addr  in  5  port 0 destination register.
- req0_data  in  32  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- req1_valid  in  1  port 1 (multi-cycle unit) write request.
- req1_addr  in  5  port 1 destination register.
- req1_data  in  32  port 1 write data.
- req1_ready  out  1  port 1 request accepted this cycle.
- WE  out  1  register-file write enable (registered).
- RegAddr  out  5  register-file write address (registered).
- WD  out  32  register-file write data (registered).
- busy_mask  out  32  bit n set when register n has a write in flight in the output stage.
- conflict_cnt  out  16  saturating count of contention cycles.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 The block SHALL accept at most one nonzero-address write per cycle toward the register file.
REQ-004 A request SHALL be accepted, with readyN=1, in the cycle it is granted; readyN SHALL be a combinational function of the valid/address inputs and rr_ptr.
REQ-005 A request with addrN=0 and validN=1 SHALL be accepted (readyN=1) in the same cycle and discarded; it SHALL NOT consume the grant, move rr_ptr, or raise WE.
REQ-006 An internal 1-bit rr_ptr SHALL select the preferred port (0 or 1).
- Both ports valid with nonzero addresses: grant the port named by rr_ptr; the other port's ready=0; rr_ptr becomes the loser's index.
- Exactly one port valid with a nonzero address: grant it; rr_ptr becomes the other port's index.
- No eligible request: rr_ptr holds.
REQ-007 A requester not granted SHALL hold valid, addr and data stable until ready=1; the block SHALL NOT buffer a losing request.
REQ-008 Latency SHALL be one cycle: a grant at edge k SHALL produce WE=1, RegAddr=addr and WD=data during cycle k+1; with no grant, WE=0 and RegAddr/WD hold their previous values.
REQ-009 busy_mask SHALL be the one-hot decode of RegAddr when WE=1, and all zeros when WE=0.
REQ-010 conflict_cnt SHALL increment by 1 on every edge where both ports present valid nonzero-address requests, including equal addresses; it SHALL saturate at 16'hFFFF.
REQ-011 When both ports target the same nonzero address, the winner SHALL be written first and the loser in a later cycle, so the loser's data is the final register value.
REQ-012 Handshake: if neither port is valid, both ready outputs SHALL be 0.

Reset
REQ-013 While rst=1 at a rising edge, the next-cycle state SHALL be:
- WE=0, RegAddr=0, WD=0
- busy_mask=0, conflict_cnt=0
- rr_ptr=0
REQ-014 While rst=1, req0_ready and req1_ready SHALL be 0, and no request SHALL be accepted.
REQ-015 Asserting rst mid-operation SHALL drop any in-flight output-stage write; WE=0 in the cycle after the reset edge.

Verification
REQ-016 Single port: req0 valid, addr=5, data=32'h1234 for one cycle -> req0_ready=1 that cycle; next cycle WE=1, RegAddr=5, WD=32'h1234, busy_mask=32'h20.
REQ-017 Contention after reset: both valid, addrs 3 and 7 -> cycle 0 grants port 0; cycle 1 grants port 1 (port 1 holds its request); WE pulses for addr 3 then addr 7; conflict_cnt=1.
REQ-018 Sustained contention, 4 cycles, port holding only until granted -> grants alternate 0,1,0,1; conflict_cnt increments only on cycles with both valid.
REQ-019 Zero address: req0 addr=0 and req1 addr=9 valid together -> both ready=1; next cycle WE=1, RegAddr=9; conflict_cnt unchanged; rr_ptr set to 0.
REQ-020 Reset mid-flight: grant on addr 4, then rst=1 on the next edge -> WE=0, busy_mask=0, conflict_cnt=0; both ready=0 while rst=1.
REQ-021 Saturation: force 65536+ contention cycles -> conflict_cnt stays at 16'hFFFF.
